// File: rtl/nvio3_div_pkg.sv
// Shared types for the divider issue/collect stage: op encoding and sequencer states.
package nvio3_div_pkg;

  typedef struct packed {
    logic rem;    // return remainder instead of quotient
    logic sgnus;  // signed dividend, unsigned divisor
    logic sgn;    // signed divide
  } div_op_t;

  localparam int unsigned DivOpW = $bits(div_op_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } div_state_t;

  // States in which the sequencer is waiting on the divider's done flag.
  function automatic logic waits_on_divider(div_state_t st);
    return (st == S_WAIT) || (st == S_DRAIN);
  endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous op FIFO holding {tag, op, a, b}; extra pointer MSB distinguishes full from empty.
module div_op_fifo import nvio3_div_pkg::*; #(
  parameter int unsigned WID   = 128,
  parameter int unsigned TAGW  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [TAGW-1:0]   wr_tag,
  input  logic [DivOpW-1:0] wr_op,
  input  logic [WID-1:0]    wr_a,
  input  logic [WID-1:0]    wr_b,
  output logic [TAGW-1:0]   rd_tag,
  output logic [DivOpW-1:0] rd_op,
  output logic [WID-1:0]    rd_a,
  output logic [WID-1:0]    rd_b,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [TAGW-1:0]   tag_mem [DEPTH];
  logic [DivOpW-1:0] op_mem  [DEPTH];
  logic [WID-1:0]    a_mem   [DEPTH];
  logic [WID-1:0]    b_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          do_push, do_pop;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign rd_tag = tag_mem[rd_ptr_q[AW-1:0]];
  assign rd_op  = op_mem[rd_ptr_q[AW-1:0]];
  assign rd_a   = a_mem[rd_ptr_q[AW-1:0]];
  assign rd_b   = b_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr_q[AW-1:0]] <= wr_tag;
      op_mem[wr_ptr_q[AW-1:0]]  <= wr_op;
      a_mem[wr_ptr_q[AW-1:0]]   <= wr_a;
      b_mem[wr_ptr_q[AW-1:0]]   <= wr_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/divider_sequencer.sv
// Issue/collect stage for the iterative divider: queues tagged ops, issues one at a time,
// captures quotient or remainder and returns it with its tag over valid/ready.
module divider_sequencer import nvio3_div_pkg::*; #(
  parameter int unsigned WID   = 128,
  parameter int unsigned TAGW  = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic [2:0]      in_op,
  input  logic [WID-1:0]  in_a,
  input  logic [WID-1:0]  in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [WID-1:0]  out_res,
  output logic            out_dbz,
  output logic            div_ld,
  output logic            div_abort,
  output logic            div_sgn,
  output logic            div_sgnus,
  output logic [WID-1:0]  div_a,
  output logic [WID-1:0]  div_b,
  input  logic [WID-1:0]  div_qo,
  input  logic [WID-1:0]  div_ro,
  input  logic            div_dbz,
  input  logic            div_done
);

  div_state_t        state_q;
  logic [TAGW-1:0]   cur_tag_q;
  logic              cur_rem_q;
  logic              skip_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [TAGW-1:0]   head_tag;
  logic [DivOpW-1:0] head_op_raw;
  div_op_t           head_op;
  logic              done_seen;

  assign fifo_push = in_valid && !fifo_full && !flush;
  assign fifo_pop  = (state_q == S_ISSUE) && !flush;
  assign in_ready  = !fifo_full;

  div_op_fifo #(
    .WID   (WID),
    .TAGW  (TAGW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_tag (in_tag),
    .wr_op  (in_op),
    .wr_a   (in_a),
    .wr_b   (in_b),
    .rd_tag (head_tag),
    .rd_op  (head_op_raw),
    .rd_a   (div_a),
    .rd_b   (div_b),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head_op   = div_op_t'(head_op_raw);
  assign div_sgn   = head_op.sgn;
  assign div_sgnus = head_op.sgnus;

  // The divider's done is stale for one cycle after ld/abort, so the first waiting cycle is masked.
  assign done_seen = waits_on_divider(state_q) && !skip_q && div_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cur_tag_q <= '0;
      cur_rem_q <= 1'b0;
      skip_q    <= 1'b0;
      div_ld    <= 1'b0;
      div_abort <= 1'b0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_res   <= '0;
      out_dbz   <= 1'b0;
    end else begin
      div_ld    <= 1'b0;
      div_abort <= 1'b0;
      skip_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty && !flush) begin
            state_q <= S_ISSUE;
            div_ld  <= 1'b1;
          end
        end
        S_ISSUE: begin
          cur_tag_q <= head_tag;
          cur_rem_q <= head_op.rem;
          skip_q    <= 1'b1;
          if (flush) begin
            state_q   <= S_DRAIN;
            div_abort <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_q   <= S_DRAIN;
            div_abort <= 1'b1;
            skip_q    <= 1'b1;
          end else if (done_seen) begin
            out_res   <= cur_rem_q ? div_ro : div_qo;
            out_dbz   <= div_dbz;
            out_tag   <= cur_tag_q;
            out_valid <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (done_seen) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a behavioural stand-in for the iterative divider.
module tb_divider_sequencer;

  localparam int unsigned WID   = 64;
  localparam int unsigned TAGW  = 6;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TAGW-1:0] in_tag = '0;
  logic [2:0]      in_op = '0;
  logic [WID-1:0]  in_a = '0;
  logic [WID-1:0]  in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TAGW-1:0] out_tag;
  logic [WID-1:0]  out_res;
  logic            out_dbz;
  logic            div_ld, div_abort, div_sgn, div_sgnus;
  logic [WID-1:0]  div_a, div_b, div_qo, div_ro;
  logic            div_dbz, div_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, ld_cyc = 0, n_ld = 0, n_ov = 0, n_ld_busy = 0;

  divider_sequencer #(
    .WID   (WID),
    .TAGW  (TAGW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_res   (out_res),
    .out_dbz   (out_dbz),
    .div_ld    (div_ld),
    .div_abort (div_abort),
    .div_sgn   (div_sgn),
    .div_sgnus (div_sgnus),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_qo    (div_qo),
    .div_ro    (div_ro),
    .div_dbz   (div_dbz),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

  // Divider stand-in: done high while idle; busy WID+3 cycles after ld (2 for divide by zero).
  logic           m_busy;
  int             m_cnt;
  logic [WID-1:0] q_calc, r_calc;

  always_comb begin
    q_calc = '0;
    r_calc = '0;
    if (div_b == '0) begin
      q_calc = {1'b0, {(WID-1){1'b1}}};
      r_calc = div_a;
    end else if (div_sgn) begin
      q_calc = $signed(div_a) / $signed(div_b);
      r_calc = $signed(div_a) % $signed(div_b);
    end else begin
      q_calc = div_a / div_b;
      r_calc = div_a % div_b;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      div_qo  <= '0;
      div_ro  <= '0;
      div_dbz <= 1'b0;
    end else if (div_abort) begin
      m_busy <= 1'b0;
    end else if (div_ld) begin
      m_busy  <= 1'b1;
      m_cnt   <= (div_b == '0) ? 1 : WID + 2;
      div_qo  <= q_calc;
      div_ro  <= r_calc;
      div_dbz <= (div_b == '0);
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  assign div_done = !m_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (div_ld) begin
      n_ld   <= n_ld + 1;
      ld_cyc <= cyc;
      if (m_busy) n_ld_busy <= n_ld_busy + 1;
    end
    if (out_valid) n_ov <= n_ov + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [TAGW-1:0] tag, input logic [2:0] op,
                      input logic [WID-1:0] a, input logic [WID-1:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_tag   = tag;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept_drop", out_valid, 1'b0);
  endtask

  task automatic expect_result(input string tag, input logic [TAGW-1:0] etag,
                               input logic [WID-1:0] eres, input logic edbz);
    wait_out({tag, "_valid"});
    check({tag, "_tag"}, out_tag, etag);
    check({tag, "_res"}, out_res, eres);
    check({tag, "_dbz"}, out_dbz, edbz);
  endtask

  initial begin
    int base_ld, base_ov, guard;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_div_ld", div_ld, 1'b0);
    check("rst_div_abort", div_abort, 1'b0);
    check("rst_out_res", out_res, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: unsigned-looking signed quotient with latency
    push(6'd5, 3'b001, 64'd10005, 64'd27);
    expect_result("t1", 6'd5, 64'd370, 1'b0);
    check("t1_latency", cyc - ld_cyc, WID + 4);
    accept();

    // 2: remainder and negative dividend
    push(6'd6, 3'b101, 64'd10005, 64'd27);
    expect_result("t2_rem", 6'd6, 64'd15, 1'b0);
    accept();
    push(6'd7, 3'b001, 64'hFFFF_FFFF_FFFF_D8EB, 64'd27);
    expect_result("t2_negq", 6'd7, 64'hFFFF_FFFF_FFFF_FE8E, 1'b0);
    accept();
    push(6'd8, 3'b101, 64'hFFFF_FFFF_FFFF_D8EB, 64'd27);
    expect_result("t2_negr", 6'd8, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    accept();

    // 3: divide by zero returns early
    push(6'd9, 3'b000, 64'd1234, 64'd0);
    expect_result("t3", 6'd9, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("t3_latency", cyc - ld_cyc, 3);
    accept();

    // 4: DEPTH+1 back-to-back pushes, then an overflow attempt that must be refused
    repeat (3) @(negedge clk);
    base_ld = n_ld;
    for (int i = 0; i < DEPTH + 1; i++) begin
      check("t4_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_tag   = TAGW'(10 + i);
      in_op    = 3'b000;
      in_a     = WID'(100 + i);
      in_b     = WID'(i + 1);
      @(negedge clk);
    end
    check("t4_full", in_ready, 1'b0);
    in_tag = 6'd15;
    @(negedge clk);
    in_valid = 1'b0;
    expect_result("t4_r0", 6'd10, 64'd100, 1'b0);
    accept();
    expect_result("t4_r1", 6'd11, 64'd50, 1'b0);
    accept();
    expect_result("t4_r2", 6'd12, 64'd34, 1'b0);
    accept();
    expect_result("t4_r3", 6'd13, 64'd25, 1'b0);
    accept();
    expect_result("t4_r4", 6'd14, 64'd20, 1'b0);
    accept();
    repeat (150) @(negedge clk);
    check("t4_ld_count", n_ld - base_ld, DEPTH + 1);

    // 5: back-pressure holds the result and blocks further issue
    push(6'd20, 3'b000, 64'd50, 64'd6);
    wait_out("t5_valid");
    push(6'd21, 3'b000, 64'd9, 64'd3);
    base_ld = n_ld;
    for (int i = 0; i < 20; i++) begin
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_res", out_res, 64'd8);
      check("t5_hold_tag", out_tag, 6'd20);
      @(negedge clk);
    end
    check("t5_no_ld", n_ld - base_ld, 0);
    accept();
    expect_result("t5_next", 6'd21, 64'd3, 1'b0);
    accept();

    // 6: flush mid-divide with two queued ops; coincident in_valid is dropped
    push(6'd30, 3'b000, 64'd1000, 64'd7);
    push(6'd31, 3'b000, 64'd11, 64'd2);
    push(6'd32, 3'b000, 64'd12, 64'd2);
    guard = 0;
    while (cyc < ld_cyc + 10 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    base_ld  = n_ld;
    base_ov  = n_ov;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_tag   = 6'd40;
    in_a     = 64'd77;
    in_b     = 64'd7;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t6_abort", div_abort, 1'b1);
    @(negedge clk);
    check("t6_abort_pulse", div_abort, 1'b0);
    repeat (150) @(negedge clk);
    check("t6_no_ld", n_ld - base_ld, 0);
    check("t6_no_valid", n_ov - base_ov, 0);
    check("t6_in_ready", in_ready, 1'b1);
    push(6'd33, 3'b100, 64'd1000, 64'd7);
    expect_result("t6_after", 6'd33, 64'd6, 1'b0);
    accept();

    // 7: asynchronous reset in the middle of a divide
    push(6'd44, 3'b000, 64'd999, 64'd3);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t7_out_valid", out_valid, 1'b0);
    check("t7_out_res", out_res, '0);
    check("t7_out_tag", out_tag, '0);
    check("t7_out_dbz", out_dbz, 1'b0);
    check("t7_div_ld", div_ld, 1'b0);
    check("t7_div_abort", div_abort, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    base_ld = n_ld;
    base_ov = n_ov;
    repeat (120) @(negedge clk);
    check("t7_no_ld", n_ld - base_ld, 0);
    check("t7_no_valid", n_ov - base_ov, 0);

    check("ld_while_busy", n_ld_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
